// File: rtl/jump_ctrl_if.sv
// jump_ctrl_if: decoder, datapath-flag, LUT-write and PC-facing signals of jump_ctrl.
//   master : decoder/datapath side (drives start, pc_in, instruction fields,
//            flags, LUT write port; observes jump outputs and flags)
//   slave  : jump_ctrl side
// Signals:
//   start, pc_in, instr_val, br_kind, cond, lut_idx           decoder / PC inputs
//   flags_we, zero_in, neg_in                                 ALU flag load
//   lut_we, lut_waddr, lut_wdata                              LUT write port
//   reljump, absjump, target, pc_reset, done, zero_q, neg_q   outputs
interface jump_ctrl_if #(
    parameter int D      = 12,
    parameter int LUT_AW = 3
);
    logic              start;
    logic [D-1:0]      pc_in;
    logic              instr_val;
    logic [1:0]        br_kind;
    logic [1:0]        cond;
    logic [LUT_AW-1:0] lut_idx;
    logic              flags_we;
    logic              zero_in;
    logic              neg_in;
    logic              lut_we;
    logic [LUT_AW-1:0] lut_waddr;
    logic [D-1:0]      lut_wdata;
    logic              reljump;
    logic              absjump;
    logic [D-1:0]      target;
    logic              pc_reset;
    logic              done;
    logic              zero_q;
    logic              neg_q;

    modport master (
        output start, pc_in, instr_val, br_kind, cond, lut_idx,
               flags_we, zero_in, neg_in, lut_we, lut_waddr, lut_wdata,
        input  reljump, absjump, target, pc_reset, done, zero_q, neg_q
    );

    modport slave (
        input  start, pc_in, instr_val, br_kind, cond, lut_idx,
               flags_we, zero_in, neg_in, lut_we, lut_waddr, lut_wdata,
        output reljump, absjump, target, pc_reset, done, zero_q, neg_q
    );
endinterface

// File: rtl/jump_ctrl.sv
// jump_ctrl: control stage directly upstream of the program counter. Holds the
// condition flags, a 2**LUT_AW-entry jump-target LUT and a run/halt FSM, and
// tells the PC whether to advance, jump relative, jump absolute or sit at 0.
// Ports:
//   clk    clock, all state updates on posedge
//   reset  asynchronous active-low reset
//   bus    jump_ctrl_if.slave (decoder fields, flags, LUT write, PC controls)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | PC held at 0 via pc_reset; start moves to RUN
// RUN   | executing; branches resolved against registered flags
// HALT  | PC frozen at halt_pc via absjump; done=1; start -> IDLE
module jump_ctrl #(
    parameter int D      = 12,
    parameter int LUT_AW = 3
) (
    input  logic        clk,
    input  logic        reset,
    jump_ctrl_if.slave  bus
);
    localparam int LUT_N = 1 << LUT_AW;

    localparam logic [1:0] BR_REL  = 2'b01;
    localparam logic [1:0] BR_ABS  = 2'b10;
    localparam logic [1:0] BR_HALT = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    state_t       state;
    logic [D-1:0] lut [LUT_N];
    logic [D-1:0] halt_pc;
    logic         zero_q;
    logic         neg_q;

    logic [D-1:0] lut_rd;
    logic         cond_ok;
    logic         reljump;
    logic         absjump;
    logic [D-1:0] target;
    logic         pc_reset;
    logic         done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            halt_pc <= '0;
            for (int i = 0; i < LUT_N; i++) begin
                lut[i] <= '0;
            end
        end else begin
            if (bus.lut_we) begin
                lut[bus.lut_waddr] <= bus.lut_wdata;
            end
            if (bus.flags_we) begin
                zero_q <= bus.zero_in;
                neg_q  <= bus.neg_in;
            end
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (bus.instr_val && bus.br_kind == BR_HALT) begin
                        state   <= HALT;
                        halt_pc <= bus.pc_in;
                    end
                end
                HALT: begin
                    if (bus.start) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read port is purely combinational, so a same-cycle write is not visible
    // until the next cycle.
    assign lut_rd = lut[bus.lut_idx];

    // Only the registered flags are consulted; a flag load in this cycle
    // affects the following instruction.
    always_comb begin
        cond_ok = 1'b0;
        case (bus.cond)
            2'b00:   cond_ok = 1'b1;
            2'b01:   cond_ok = zero_q;
            2'b10:   cond_ok = ~zero_q;
            default: cond_ok = neg_q;
        endcase
    end

    always_comb begin
        reljump  = 1'b0;
        absjump  = 1'b0;
        target   = '0;
        pc_reset = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: pc_reset = 1'b1;
            RUN: begin
                target = lut_rd;
                if (bus.instr_val) begin
                    case (bus.br_kind)
                        BR_REL: reljump = cond_ok;
                        BR_ABS: absjump = cond_ok;
                        BR_HALT: begin
                            // Hold the PC on the halting instruction itself.
                            absjump = 1'b1;
                            target  = bus.pc_in;
                        end
                        default: ;
                    endcase
                end
            end
            HALT: begin
                absjump = 1'b1;
                target  = halt_pc;
                done    = 1'b1;
            end
            default: pc_reset = 1'b1;
        endcase
    end

    assign bus.reljump  = reljump;
    assign bus.absjump  = absjump;
    assign bus.target   = target;
    assign bus.pc_reset = pc_reset;
    assign bus.done     = done;
    assign bus.zero_q   = zero_q;
    assign bus.neg_q    = neg_q;
endmodule

// File: tb/tb_jump_ctrl.sv
module tb_jump_ctrl;
    logic        clk;
    logic        reset;
    logic [11:0] pc;
    int          checks;
    int          failures;
    logic [15:0] sb[$];
    logic [15:0] exp_v;
    logic [11:0] lut_m [8];

    jump_ctrl_if #(.D(12), .LUT_AW(3)) bus ();

    jump_ctrl #(.D(12), .LUT_AW(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // PC model: the register this block steers.
    always @(posedge clk or negedge reset) begin
        if (!reset)            pc <= 12'h000;
        else if (bus.pc_reset) pc <= 12'h000;
        else if (bus.absjump)  pc <= bus.target;
        else if (bus.reljump)  pc <= pc + bus.target;
        else                   pc <= pc + 12'h001;
    end
    assign bus.pc_in = pc;

    wire [15:0] obs = {bus.pc_reset, bus.done, bus.reljump, bus.absjump, bus.target};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] e(input logic pr, input logic dn, input logic rj,
                                      input logic aj, input logic [11:0] tg);
        return {pr, dn, rj, aj, tg};
    endfunction

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] k, input logic [1:0] c,
                         input logic [2:0] idx, input logic [15:0] ex);
        bus.instr_val = v;
        bus.br_kind   = k;
        bus.cond      = c;
        bus.lut_idx   = idx;
        sb.push_back(ex);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        drive(1'b1, 2'b01, 2'b00, 3'd2, e(1, 0, 0, 0, 12'h000));
        #3;
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL reset_outputs obs=%h exp=%h", obs, exp_v); end
        checks++;
        if ({bus.zero_q, bus.neg_q} !== 2'b00) begin failures++; $display("FAIL reset_flags obs=%b exp=00", {bus.zero_q, bus.neg_q}); end
        checks++;
        if (pc !== 12'h000) begin failures++; $display("FAIL reset_pc obs=%h exp=000", pc); end
        #2 reset = 1'b1;
        cyc();
    endtask

    task automatic test_lut_load_idle;
        for (int i = 1; i < 8; i++) begin
            bus.lut_we    = 1'b1;
            bus.lut_waddr = 3'(i);
            bus.lut_wdata = lut_m[i];
            drive(1'b0, 2'b00, 2'b00, 3'(i), e(1, 0, 0, 0, 12'h000));
            #3;
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin failures++; $display("FAIL idle_outputs obs=%h exp=%h", obs, exp_v); end
            checks++;
            if (pc !== 12'h000) begin failures++; $display("FAIL idle_pc_hold obs=%h exp=000", pc); end
            cyc();
        end
        bus.lut_we = 1'b0;
    endtask

    task automatic test_rel_jump;
        bus.start = 1'b1;
        drive(1'b0, 2'b00, 2'b00, 3'd0, e(1, 0, 0, 0, 12'h000));
        #3;
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL start_in_idle obs=%h exp=%h", obs, exp_v); end
        cyc();
        // start held high in RUN must be ignored
        for (int n = 0; n < 20 && pc != 12'd10; n++) begin
            drive(1'b0, 2'b00, 2'b00, 3'd0, e(0, 0, 0, 0, 12'h000));
            #3;
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin failures++; $display("FAIL run_advance obs=%h exp=%h", obs, exp_v); end
            cyc();
        end
        bus.start = 1'b0;
        checks++;
        if (pc !== 12'd10) begin failures++; $display("FAIL run_reach_pc10 obs=%h exp=00a", pc); end
        drive(1'b1, 2'b01, 2'b00, 3'd2, e(0, 0, 1, 0, 12'hFFE));
        #3;
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL rel_jump obs=%h exp=%h", obs, exp_v); end
        cyc();
        checks++;
        if (pc !== 12'h008) begin failures++; $display("FAIL rel_jump_pc obs=%h exp=008", pc); end
    endtask

    task automatic test_back_to_back;
        drive(1'b1, 2'b01, 2'b00, 3'd2, e(0, 0, 1, 0, 12'hFFE));
        #3;
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL b2b_first obs=%h exp=%h", obs, exp_v); end
        cyc();
        drive(1'b1, 2'b01, 2'b00, 3'd4, e(0, 0, 1, 0, 12'h0AB));
        #3;
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL b2b_second obs=%h exp=%h", obs, exp_v); end
        cyc();
        checks++;
        if (pc !== 12'h0B1) begin failures++; $display("FAIL b2b_pc obs=%h exp=0b1", pc); end
    endtask

    task automatic test_flags;
        bus.flags_we = 1'b1;
        bus.zero_in  = 1'b1;
        bus.neg_in   = 1'b0;
        drive(1'b1, 2'b10, 2'b01, 3'd4, e(0, 0, 0, 0, 12'h0AB));
        #3;
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL flag_same_cycle obs=%h exp=%h", obs, exp_v); end
        cyc();
        bus.flags_we = 1'b0;
        checks++;
        if (bus.zero_q !== 1'b1) begin failures++; $display("FAIL zero_q_load obs=%b exp=1", bus.zero_q); end
        drive(1'b1, 2'b10, 2'b01, 3'd4, e(0, 0, 0, 1, 12'h0AB));
        #3;
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL flag_next_cycle obs=%h exp=%h", obs, exp_v); end
        cyc();
        checks++;
        if (pc !== 12'h0AB) begin failures++; $display("FAIL abs_jump_pc obs=%h exp=0ab", pc); end
        drive(1'b1, 2'b01, 2'b10, 3'd2, e(0, 0, 0, 0, 12'hFFE));
        #3;
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL nz_not_taken obs=%h exp=%h", obs, exp_v); end
        cyc();
        drive(1'b1, 2'b10, 2'b11, 3'd4, e(0, 0, 0, 0, 12'h0AB));
        #3;
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL neg_not_taken obs=%h exp=%h", obs, exp_v); end
        cyc();
        bus.flags_we = 1'b1;
        bus.zero_in  = 1'b0;
        bus.neg_in   = 1'b1;
        drive(1'b0, 2'b00, 2'b00, 3'd0, e(0, 0, 0, 0, 12'h000));
        cyc();
        void'(sb.pop_front());
        bus.flags_we = 1'b0;
        drive(1'b1, 2'b10, 2'b11, 3'd4, e(0, 0, 0, 1, 12'h0AB));
        #3;
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL neg_taken obs=%h exp=%h", obs, exp_v); end
        cyc();
        drive(1'b1, 2'b01, 2'b10, 3'd5, e(0, 0, 1, 0, 12'h002));
        #3;
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL nz_taken obs=%h exp=%h", obs, exp_v); end
        cyc();
        checks++;
        if (pc !== 12'h0AD) begin failures++; $display("FAIL nz_taken_pc obs=%h exp=0ad", pc); end
    endtask

    task automatic test_lut_bypass;
        bus.lut_we    = 1'b1;
        bus.lut_waddr = 3'd1;
        bus.lut_wdata = 12'h040;
        drive(1'b0, 2'b00, 2'b00, 3'd1, e(0, 0, 0, 0, 12'h777));
        #3;
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL lut_old_value obs=%h exp=%h", obs, exp_v); end
        cyc();
        bus.lut_we = 1'b0;
        drive(1'b0, 2'b00, 2'b00, 3'd1, e(0, 0, 0, 0, 12'h040));
        #3;
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL lut_new_value obs=%h exp=%h", obs, exp_v); end
        cyc();
    endtask

    task automatic test_wrap;
        drive(1'b1, 2'b10, 2'b00, 3'd6, e(0, 0, 0, 1, 12'hFFF));
        #3;
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL abs_to_fff obs=%h exp=%h", obs, exp_v); end
        cyc();
        checks++;
        if (pc !== 12'hFFF) begin failures++; $display("FAIL pc_fff obs=%h exp=fff", pc); end
        drive(1'b1, 2'b01, 2'b00, 3'd5, e(0, 0, 1, 0, 12'h002));
        #3;
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL rel_wrap obs=%h exp=%h", obs, exp_v); end
        cyc();
        checks++;
        if (pc !== 12'h001) begin failures++; $display("FAIL rel_wrap_pc obs=%h exp=001", pc); end
    endtask

    task automatic test_halt;
        drive(1'b1, 2'b10, 2'b00, 3'd7, e(0, 0, 0, 1, 12'h005));
        #3;
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL abs_to_5 obs=%h exp=%h", obs, exp_v); end
        cyc();
        drive(1'b1, 2'b11, 2'b00, 3'd0, e(0, 0, 0, 1, 12'h005));
        #3;
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL halt_cycle obs=%h exp=%h", obs, exp_v); end
        cyc();
        for (int n = 0; n < 10; n++) begin
            if (n == 3) drive(1'b1, 2'b01, 2'b00, 3'd2, e(0, 1, 0, 1, 12'h005));
            else        drive(1'b0, 2'b00, 2'b00, 3'd2, e(0, 1, 0, 1, 12'h005));
            #3;
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin failures++; $display("FAIL halted obs=%h exp=%h n=%0d", obs, exp_v, n); end
            checks++;
            if (pc !== 12'h005) begin failures++; $display("FAIL halted_pc obs=%h exp=005 n=%0d", pc, n); end
            cyc();
        end
        bus.start = 1'b1;
        drive(1'b0, 2'b00, 2'b00, 3'd2, e(0, 1, 0, 1, 12'h005));
        #3;
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL halt_start obs=%h exp=%h", obs, exp_v); end
        cyc();
        bus.start = 1'b0;
        drive(1'b0, 2'b00, 2'b00, 3'd2, e(1, 0, 0, 0, 12'h000));
        #3;
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL halt_to_idle obs=%h exp=%h", obs, exp_v); end
        cyc();
        checks++;
        if (pc !== 12'h000) begin failures++; $display("FAIL idle_pc_zero obs=%h exp=000", pc); end
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        drive(1'b0, 2'b00, 2'b00, 3'd2, e(0, 0, 0, 0, 12'hFFE));
        #3;
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL restart_run obs=%h exp=%h", obs, exp_v); end
        cyc();
    endtask

    task automatic test_reset_mid;
        bus.flags_we = 1'b1;
        bus.zero_in  = 1'b1;
        bus.neg_in   = 1'b1;
        cyc();
        bus.flags_we = 1'b0;
        drive(1'b1, 2'b01, 2'b00, 3'd2, e(0, 0, 1, 0, 12'hFFE));
        #3;
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL mid_jump obs=%h exp=%h", obs, exp_v); end
        #2 reset = 1'b0;
        #1;
        sb.push_back(e(1, 0, 0, 0, 12'h000));
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL async_reset obs=%h exp=%h", obs, exp_v); end
        checks++;
        if ({bus.zero_q, bus.neg_q} !== 2'b00) begin failures++; $display("FAIL async_reset_flags obs=%b exp=00", {bus.zero_q, bus.neg_q}); end
        cyc();
        #3 reset = 1'b1;
        cyc();
        checks++;
        if (pc !== 12'h000) begin failures++; $display("FAIL post_reset_pc obs=%h exp=000", pc); end
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        drive(1'b0, 2'b00, 2'b00, 3'd3, e(0, 0, 0, 0, 12'h000));
        #3;
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL lut3_cleared obs=%h exp=%h", obs, exp_v); end
        cyc();
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.instr_val = 1'b0;
        bus.br_kind   = 2'b00;
        bus.cond      = 2'b00;
        bus.lut_idx   = 3'd0;
        bus.flags_we  = 1'b0;
        bus.zero_in   = 1'b0;
        bus.neg_in    = 1'b0;
        bus.lut_we    = 1'b0;
        bus.lut_waddr = 3'd0;
        bus.lut_wdata = 12'h000;
        lut_m[0] = 12'h000;
        lut_m[1] = 12'h777;
        lut_m[2] = 12'hFFE;
        lut_m[3] = 12'h123;
        lut_m[4] = 12'h0AB;
        lut_m[5] = 12'h002;
        lut_m[6] = 12'hFFF;
        lut_m[7] = 12'h005;

        test_reset();
        test_lut_load_idle();
        test_rel_jump();
        test_back_to_back();
        test_flags();
        test_lut_bypass();
        test_wrap();
        test_halt();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
